interface_hcsr04_multi: RTL and testbench
=========================================

Name: interface_hcsr04_multi

Overview:
Parametrised multi-channel datapath and controller for HC-SR04 ultrasonic sensors. It periodically sweeps CANAIS sensors round-robin. For each channel it issues a trigger pulse, times the echo, converts the time to binary centimetres, flags timeouts and classifies the distance into a floor index. It replaces the single-channel, externally sequenced BCD interface in the lift position subsystem with one self-contained block that has a per-channel result bank.

Parameters:
CANAIS, 2, number of sensor channels (>=1)
LARGURA, 9, distance width in bits (binary cm); MAX_CM < 2^LARGURA
CICLOS_CM, 2941, clock cycles of echo per cm
CICLOS_TRIGGER, 500, trigger pulse width in cycles (10 us @ 50 MHz)
MAX_CM, 400, saturation distance; reaching it while echo is high is an error
TIMEOUT_ECO, 1500000, max cycles waiting for echo rise after trigger ends
PERIODO, 50000000, cycles between sweep starts
CM_ANDAR, 20, cm per floor
ANDARES, 4, number of floors; andar saturates at ANDARES-1

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
habilita  in  1  level; while high, sweeps run periodically
eco  in  CANAIS  raw echo inputs (asynchronous)
trigger  out  CANAIS  trigger outputs, one-hot or zero
ocupado  out  1  high from sweep start until the last channel result is registered
pronto  out  1  one-cycle pulse per channel result
canal  out  clog2(CANAIS) (min 1)  channel of the latest result
medida  out  LARGURA  latest distance in cm
andar  out  clog2(ANDARES) (min 1)  floor of medida
erro  out  CANAIS  per-channel timeout/saturation flag of the latest measurement
distancias  out  CANAIS*LARGURA  result bank; channel i at [i*LARGURA +: LARGURA]

Behaviour:
- Reset (async): all outputs 0, FSM in OCIOSO, all counters 0, bank cleared, synchronisers cleared.
- eco passes through a 2-FF synchroniser per channel (eco_s). Only eco_s of the active channel is used.
- Period counter runs only while habilita=1, wrapping at PERIODO-1. A tick starts a sweep. The first sweep starts on the edge after habilita rises. A tick arriving while ocupado=1 is dropped. With habilita=0 the counter is cleared.
- FSM states:
  - OCIOSO: wait for a sweep start; then ch:=0, go to DISPARA.
  - DISPARA: trigger[ch]=1 for exactly CICLOS_TRIGGER cycles; then go to AGUARDA.
  - AGUARDA: wait for a rising edge of eco_s (a low->high transition seen inside this state; eco_s high on entry is not a rise). If TIMEOUT_ECO cycles pass with no rise, go to REGISTRA as an error with value MAX_CM.
  - MEDE: a sub-counter counts eco_s-high cycles and wraps at CICLOS_CM-1, incrementing cm. Result = floor(n/CICLOS_CM), where n = number of eco_s-high cycles. If cm reaches MAX_CM while eco_s is still high, go to REGISTRA as an error. A falling edge of eco_s goes to REGISTRA with no error.
  - REGISTRA: single cycle. The bank slot for ch, medida, canal and erro[ch] update. erro[ch] is set on error and cleared on success; other erro bits hold. pronto=1 on the next cycle, concurrent with the updated outputs.
  - PROXIMO: if ch=CANAIS-1 or habilita=0, go to OCIOSO with ocupado=0. Otherwise ch++ and go to DISPARA.
- andar = min(medida / CM_ANDAR, ANDARES-1), combinational from registered medida.
- Dropping habilita mid-channel completes the current channel only.
- Reset mid-measurement: trigger drops immediately (asynchronously). No pronto is produced.
- Width rule: the cm counter never exceeds MAX_CM, so no wrap occurs.

Test Plan:
Parameters for all scenarios: CANAIS=2, LARGURA=6, CICLOS_CM=10, CICLOS_TRIGGER=5, MAX_CM=30, TIMEOUT_ECO=100, PERIODO=2000, CM_ANDAR=10, ANDARES=4.
1. Assert reset with random eco -> all outputs 0. Release reset with habilita=0 -> trigger stays 0 for 3000 cycles.
2. habilita=1; eco[0] high for 125 cycles starting 10 cycles after trigger[0] falls -> trigger[0] high for exactly 5 cycles, trigger[1]=0; pronto pulse with canal=0, medida=12, andar=1, erro[0]=0, distancias[5:0]=12.
3. Continue the sweep with eco[1] held low -> after 100 cycles in AGUARDA: pronto, canal=1, medida=30, andar=3, erro[1]=1, distancias[11:6]=30, ocupado falls. Next sweep starts 2000 cycles after the first.
4. eco[0] high for 400 cycles -> result at the cycle cm reaches 30 (before eco falls): medida=30, erro[0]=1. A following good 55-cycle echo -> medida=5, erro[0]=0.
5. Drop habilita during ch0 MEDE -> ch0 result is registered, trigger[1] never asserts, ocupado=0, no further sweeps.
6. Assert reset during ch1 MEDE -> trigger, pronto, bank and erro are 0 immediately and no stale pronto appears after release. eco[0] held high from trigger start -> timeout error (no rise seen).

Source files
------------

// File: rtl/interface_hcsr04_multi.sv
// Round-robin controller for several HC-SR04 sensors: trigger, echo timing,
// cm conversion, timeout/saturation flags and a per-channel result bank.
module interface_hcsr04_multi #(
  parameter int CANAIS         = 2,
  parameter int LARGURA        = 9,
  parameter int CICLOS_CM      = 2941,
  parameter int CICLOS_TRIGGER = 500,
  parameter int MAX_CM         = 400,
  parameter int TIMEOUT_ECO    = 1500000,
  parameter int PERIODO        = 50000000,
  parameter int CM_ANDAR       = 20,
  parameter int ANDARES        = 4,
  localparam int CW = (CANAIS > 1) ? $clog2(CANAIS) : 1,
  localparam int AW = (ANDARES > 1) ? $clog2(ANDARES) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      habilita,
  input  logic [CANAIS-1:0]         eco,
  output logic [CANAIS-1:0]         trigger,
  output logic                      ocupado,
  output logic                      pronto,
  output logic [CW-1:0]             canal,
  output logic [LARGURA-1:0]        medida,
  output logic [AW-1:0]             andar,
  output logic [CANAIS-1:0]         erro,
  output logic [CANAIS*LARGURA-1:0] distancias
);

  localparam int M1      = (CICLOS_TRIGGER > CICLOS_CM) ? CICLOS_TRIGGER : CICLOS_CM;
  localparam int CNT_MAX = (M1 > TIMEOUT_ECO) ? M1 : TIMEOUT_ECO;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam int PW      = (PERIODO > 1) ? $clog2(PERIODO) : 1;

  typedef enum logic [2:0] {OCIOSO, DISPARA, AGUARDA, MEDE, REGISTRA, PROXIMO} estado_t;

  estado_t                   estado_q, estado_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [LARGURA-1:0]        cm_q, cm_d;
  logic                      falha_q, falha_d;
  logic                      arm_q, arm_d;
  logic [PW-1:0]             per_q, per_d;
  logic [CANAIS-1:0]         sync1_q, sync1_d;
  logic [CANAIS-1:0]         eco_s_q, eco_s_d;
  logic [CANAIS*LARGURA-1:0] bank_q, bank_d;
  logic [LARGURA-1:0]        medida_q, medida_d;
  logic [CW-1:0]             canal_q, canal_d;
  logic [CANAIS-1:0]         erro_q, erro_d;
  logic                      pronto_q, pronto_d;
  logic                      inicio;
  logic                      eco_ativo;
  logic [LARGURA-1:0]        quociente;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      ch_q     <= '0;
      cnt_q    <= '0;
      cm_q     <= '0;
      falha_q  <= 1'b0;
      arm_q    <= 1'b0;
      per_q    <= '0;
      sync1_q  <= '0;
      eco_s_q  <= '0;
      bank_q   <= '0;
      medida_q <= '0;
      canal_q  <= '0;
      erro_q   <= '0;
      pronto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      cm_q     <= cm_d;
      falha_q  <= falha_d;
      arm_q    <= arm_d;
      per_q    <= per_d;
      sync1_q  <= sync1_d;
      eco_s_q  <= eco_s_d;
      bank_q   <= bank_d;
      medida_q <= medida_d;
      canal_q  <= canal_d;
      erro_q   <= erro_d;
      pronto_q <= pronto_d;
    end
  end

  // Sweep ticks land on per_q == 0, so the first one follows habilita directly.
  always_comb begin
    sync1_d = eco;
    eco_s_d = sync1_q;
    per_d   = '0;
    if (habilita) per_d = (per_q == PW'(PERIODO - 1)) ? '0 : per_q + 1'b1;
    inicio    = habilita && (per_q == '0);
    eco_ativo = eco_s_q[ch_q];
  end

  always_comb begin
    estado_d = estado_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    cm_d     = cm_q;
    falha_d  = falha_q;
    arm_d    = arm_q;
    bank_d   = bank_q;
    medida_d = medida_q;
    canal_d  = canal_q;
    erro_d   = erro_q;
    pronto_d = 1'b0;
    case (estado_q)
      OCIOSO: if (inicio) begin
        ch_d     = '0;
        cnt_d    = '0;
        estado_d = DISPARA;
      end
      DISPARA: if (cnt_q == CNTW'(CICLOS_TRIGGER - 1)) begin
        cnt_d    = '0;
        arm_d    = 1'b0;
        estado_d = AGUARDA;
      end else cnt_d = cnt_q + 1'b1;
      AGUARDA: begin
        // A rise only counts once eco_s has been seen low inside this state.
        arm_d = arm_q | ~eco_ativo;
        if (arm_q && eco_ativo) begin
          estado_d = MEDE;
          falha_d  = 1'b0;
          if (CICLOS_CM == 1) begin
            cnt_d = '0;
            cm_d  = LARGURA'(1);
          end else begin
            cnt_d = CNTW'(1);
            cm_d  = '0;
          end
        end else if (cnt_q == CNTW'(TIMEOUT_ECO - 1)) begin
          estado_d = REGISTRA;
          falha_d  = 1'b1;
          cm_d     = LARGURA'(MAX_CM);
        end else cnt_d = cnt_q + 1'b1;
      end
      MEDE: if (!eco_ativo) begin
        estado_d = REGISTRA;
        falha_d  = 1'b0;
      end else if (cnt_q == CNTW'(CICLOS_CM - 1)) begin
        cnt_d = '0;
        cm_d  = cm_q + 1'b1;
        if (cm_q == LARGURA'(MAX_CM - 1)) begin
          estado_d = REGISTRA;
          falha_d  = 1'b1;
        end
      end else cnt_d = cnt_q + 1'b1;
      REGISTRA: begin
        bank_d[ch_q*LARGURA +: LARGURA] = cm_q;
        medida_d     = cm_q;
        canal_d      = ch_q;
        erro_d[ch_q] = falha_q;
        pronto_d     = 1'b1;
        estado_d     = PROXIMO;
      end
      PROXIMO: if (ch_q == CW'(CANAIS - 1) || !habilita) estado_d = OCIOSO;
      else begin
        ch_d     = ch_q + 1'b1;
        cnt_d    = '0;
        estado_d = DISPARA;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Trigger decodes straight from the state register so reset kills it at once.
  always_comb begin
    trigger = '0;
    if (estado_q == DISPARA) trigger[ch_q] = 1'b1;
    ocupado    = (estado_q != OCIOSO);
    pronto     = pronto_q;
    canal      = canal_q;
    medida     = medida_q;
    erro       = erro_q;
    distancias = bank_q;
    quociente  = medida_q / LARGURA'(CM_ANDAR);
    if (quociente > LARGURA'(ANDARES - 1)) andar = AW'(ANDARES - 1);
    else andar = AW'(quociente);
  end

endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// Randomised bench for interface_hcsr04_multi: echo pulses are driven per
// channel and results compared against an arithmetic distance model.
module tb_interface_hcsr04_multi;
  localparam int CANAIS = 2, LARGURA = 6, CICLOS_CM = 10, CICLOS_TRIGGER = 5;
  localparam int MAX_CM = 30, TIMEOUT_ECO = 100, PERIODO = 2000;
  localparam int CM_ANDAR = 10, ANDARES = 4;

  logic        clock = 1'b0;
  logic        reset, habilita;
  logic [1:0]  eco;
  logic [1:0]  trigger;
  logic        ocupado, pronto;
  logic [0:0]  canal;
  logic [5:0]  medida;
  logic [1:0]  andar;
  logic [1:0]  erro;
  logic [11:0] distancias;

  int total = 0, bad = 0, cyc = 0, first_rise = 0;
  int bank_m[2];
  bit err_m[2];

  typedef struct {
    bit          trig_seen;
    int          wid;
    bit          onehot_ok;
    int          t_rise;
    bit          pr_seen;
    bit          early;
    logic [22:0] res;
    logic        pronto_after;
    logic [2:0]  snap_out;
    logic [13:0] snap_bank;
  } obs_t;

  interface_hcsr04_multi #(
    .CANAIS(CANAIS), .LARGURA(LARGURA), .CICLOS_CM(CICLOS_CM),
    .CICLOS_TRIGGER(CICLOS_TRIGGER), .MAX_CM(MAX_CM), .TIMEOUT_ECO(TIMEOUT_ECO),
    .PERIODO(PERIODO), .CM_ANDAR(CM_ANDAR), .ANDARES(ANDARES)
  ) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .eco(eco),
    .trigger(trigger), .ocupado(ocupado), .pronto(pronto), .canal(canal),
    .medida(medida), .andar(andar), .erro(erro), .distancias(distancias)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // len <= 0 means no usable rise (timeout); long echoes saturate.
  function automatic int exp_cm(input int len);
    if (len <= 0 || len >= MAX_CM * CICLOS_CM) return MAX_CM;
    return len / CICLOS_CM;
  endfunction

  function automatic bit exp_err(input int len);
    return (len <= 0 || len >= MAX_CM * CICLOS_CM);
  endfunction

  function automatic int exp_andar(input int cm);
    return (cm / CM_ANDAR > ANDARES - 1) ? ANDARES - 1 : cm / CM_ANDAR;
  endfunction

  function automatic logic [22:0] exp_pack(input int ch);
    return {1'(ch), 6'(bank_m[ch]), 2'(exp_andar(bank_m[ch])), err_m[1], err_m[0],
            6'(bank_m[1]), 6'(bank_m[0])};
  endfunction

  task automatic model_update(input int ch, input int len);
    bank_m[ch] = exp_cm(len);
    err_m[ch]  = exp_err(len);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      bank_m[k] = 0;
      err_m[k]  = 1'b0;
    end
  endtask

  // act 1 drops habilita, act 2 asserts reset, at echo cycle act_at.
  task automatic do_channel(input int ch, input int dly, input int len,
                            input int act, input int act_at, output obs_t o);
    int i;
    o = '{default: 0};
    i = 0;
    while (trigger[ch] !== 1'b1 && i < 2600) begin
      @(negedge clock);
      i++;
    end
    if (trigger[ch] !== 1'b1) return;
    o.trig_seen = 1'b1;
    o.t_rise    = cyc;
    o.onehot_ok = (trigger === 2'(1 << ch));
    if (len < 0) eco[ch] = 1'b1;
    o.wid = 1;
    while (o.wid < 50) begin
      @(negedge clock);
      if (trigger[ch] !== 1'b1) break;
      o.wid++;
      if (trigger !== 2'(1 << ch)) o.onehot_ok = 1'b0;
    end
    if (len > 0) begin
      repeat (dly) @(negedge clock);
      eco[ch] = 1'b1;
      for (int k = 0; k < len; k++) begin
        @(negedge clock);
        if (act == 1 && k == act_at) habilita = 1'b0;
        if (act == 2 && k == act_at) begin
          reset = 1'b1;
          #1;
          o.snap_out  = {trigger, pronto};
          o.snap_bank = {erro, distancias};
          eco[ch] = 1'b0;
          return;
        end
        if (pronto === 1'b1) begin
          o.early = 1'b1;
          break;
        end
      end
      eco[ch] = 1'b0;
    end
    i = 0;
    while (pronto !== 1'b1 && i < 300) begin
      @(negedge clock);
      i++;
    end
    o.pr_seen = (pronto === 1'b1);
    o.res = {canal, medida, andar, erro, distancias};
    @(negedge clock);
    o.pronto_after = pronto;
    if (len < 0) eco[ch] = 1'b0;
  endtask

  task automatic test_reset();
    int viol;
    reset = 1'b1;
    habilita = 1'b0;
    repeat (4) begin
      @(negedge clock);
      eco = 2'($urandom);
    end
    total++;
    if ({trigger, ocupado, pronto, canal, medida, andar, erro, distancias} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {trigger, ocupado, pronto, canal, medida, andar, erro, distancias});
    end
    reset = 1'b0;
    viol = 0;
    repeat (3000) begin
      @(negedge clock);
      eco = 2'($urandom);
      if (trigger !== 2'b00 || ocupado !== 1'b0 || pronto !== 1'b0) viol++;
    end
    eco = 2'b00;
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL idle_no_trigger: got %0d active cycles want 0", viol);
    end
    $display("reset and idle window checked");
  endtask

  task automatic test_basic();
    obs_t o;
    model_clear();
    @(negedge clock);
    habilita = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      do_channel(ch, 10, (ch == 0) ? 125 : 0, 0, 0, o);
      model_update(ch, (ch == 0) ? 125 : 0);
      if (ch == 0) first_rise = o.t_rise;
      total++;
      if (o.wid !== CICLOS_TRIGGER) begin
        bad++;
        $display("FAIL trig_width_ch%0d: got %0d want %0d", ch, o.wid, CICLOS_TRIGGER);
      end
      total++;
      if (o.onehot_ok !== 1'b1) begin
        bad++;
        $display("FAIL trig_onehot_ch%0d: got %b want 1", ch, o.onehot_ok);
      end
      total++;
      if (o.pr_seen !== 1'b1) begin
        bad++;
        $display("FAIL pronto_seen_ch%0d: got %b want 1", ch, o.pr_seen);
      end
      total++;
      if (o.res !== exp_pack(ch)) begin
        bad++;
        $display("FAIL result_ch%0d: got %h want %h", ch, o.res, exp_pack(ch));
      end
      total++;
      if (o.pronto_after !== 1'b0) begin
        bad++;
        $display("FAIL pronto_width_ch%0d: got %b want 0", ch, o.pronto_after);
      end
      $display("txn basic ch=%0d medida=%0d erro=%b", ch, medida, erro);
    end
    total++;
    if (ocupado !== 1'b0) begin
      bad++;
      $display("FAIL ocupado_fall: got %b want 0", ocupado);
    end
  endtask

  task automatic test_saturation();
    obs_t o;
    int len1;
    do_channel(0, 10, 400, 0, 0, o);
    model_update(0, 400);
    total++;
    if (o.t_rise - first_rise !== PERIODO) begin
      bad++;
      $display("FAIL sweep_period: got %0d want %0d", o.t_rise - first_rise, PERIODO);
    end
    total++;
    if (o.early !== 1'b1) begin
      bad++;
      $display("FAIL saturation_early: got %b want 1", o.early);
    end
    total++;
    if (o.res !== exp_pack(0)) begin
      bad++;
      $display("FAIL saturation_result: got %h want %h", o.res, exp_pack(0));
    end
    $display("txn sat ch=0 medida=%0d erro=%b", medida, erro);
    for (int s = 0; s < 2; s++) begin
      if (s == 1) begin
        do_channel(0, 10, 55, 0, 0, o);
        model_update(0, 55);
        total++;
        if (o.res !== exp_pack(0)) begin
          bad++;
          $display("FAIL recover_result: got %h want %h", o.res, exp_pack(0));
        end
        $display("txn sat ch=0 medida=%0d erro=%b", medida, erro);
      end
      len1 = $urandom_range(20, 250);
      do_channel(1, $urandom_range(3, 60), len1, 0, 0, o);
      model_update(1, len1);
      total++;
      if (o.res !== exp_pack(1)) begin
        bad++;
        $display("FAIL sat_ch1_result: got %h want %h", o.res, exp_pack(1));
      end
      $display("txn sat ch=1 len=%0d medida=%0d erro=%b", len1, medida, erro);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int len, dly, kind;
    for (int s = 0; s < 6; s++) begin
      for (int ch = 0; ch < 2; ch++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0) len = 0;
        else if (kind == 1) len = $urandom_range(300, 340);
        else len = $urandom_range(1, 299);
        dly = $urandom_range(2, 80);
        do_channel(ch, dly, len, 0, 0, o);
        model_update(ch, len);
        total++;
        if (o.res !== exp_pack(ch) || o.wid !== CICLOS_TRIGGER) begin
          bad++;
          $display("FAIL random_s%0d_ch%0d: got %h wid %0d want %h wid %0d",
                   s, ch, o.res, o.wid, exp_pack(ch), CICLOS_TRIGGER);
        end
        $display("txn random sweep=%0d ch=%0d len=%0d dly=%0d medida=%0d erro=%b",
                 s, ch, len, dly, medida, erro);
      end
    end
  endtask

  task automatic test_habilita_drop();
    obs_t o;
    int viol;
    do_channel(0, 10, 150, 1, 50, o);
    model_update(0, 150);
    total++;
    if (o.res !== exp_pack(0)) begin
      bad++;
      $display("FAIL drop_result: got %h want %h", o.res, exp_pack(0));
    end
    viol = 0;
    repeat (3000) begin
      @(negedge clock);
      if (trigger !== 2'b00 || pronto !== 1'b0 || ocupado !== 1'b0) viol++;
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL drop_quiet: got %0d active cycles want 0", viol);
    end
    $display("txn drop ch=0 medida=%0d erro=%b", medida, erro);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int viol, len1;
    habilita = 1'b1;
    do_channel(0, 10, 80, 0, 0, o);
    model_update(0, 80);
    total++;
    if (o.res !== exp_pack(0)) begin
      bad++;
      $display("FAIL pre_reset_result: got %h want %h", o.res, exp_pack(0));
    end
    do_channel(1, 10, 150, 2, 50, o);
    model_clear();
    total++;
    if (o.snap_out !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_outputs: got %b want 000", o.snap_out);
    end
    total++;
    if (o.snap_bank !== 14'd0) begin
      bad++;
      $display("FAIL reset_mid_bank: got %h want 0", o.snap_bank);
    end
    habilita = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    viol = 0;
    repeat (50) begin
      @(negedge clock);
      if (pronto !== 1'b0 || trigger !== 2'b00) viol++;
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL stale_pronto: got %0d active cycles want 0", viol);
    end
    habilita = 1'b1;
    do_channel(0, 0, -1, 0, 0, o);
    model_update(0, -1);
    total++;
    if (o.res !== exp_pack(0)) begin
      bad++;
      $display("FAIL held_high_timeout: got %h want %h", o.res, exp_pack(0));
    end
    $display("txn held-high ch=0 medida=%0d erro=%b", medida, erro);
    len1 = $urandom_range(20, 250);
    do_channel(1, 10, len1, 0, 0, o);
    model_update(1, len1);
    total++;
    if (o.res !== exp_pack(1)) begin
      bad++;
      $display("FAIL post_reset_ch1: got %h want %h", o.res, exp_pack(1));
    end
    $display("txn post-reset ch=1 len=%0d medida=%0d erro=%b", len1, medida, erro);
    habilita = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    habilita = 1'b0;
    eco = 2'b00;
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_habilita_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
